// File: rtl/ctr_block_counter.sv
// AES-CTR counter-block generator: load {nonce, count}, then emit a programmed number of blocks on valid/ready.
// Optional build macro CTR_WRAP_DET_EN enables the sticky counter-field wrap indicator.
module ctr_block_counter #(
   parameter int unsigned N    = 128,
   parameter int unsigned CW   = 32,
   parameter int unsigned M    = 8,
   parameter int unsigned LIMW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [N-1:0]    load_val,
   input  logic [M-1:0]    inc,
   input  logic [LIMW-1:0] num_blocks,
   input  logic            start,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_block,
   output logic            busy,
   output logic            done,
   output logic            wrap_flag
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N-1:0]    r_ctr;
   logic [N-1:0]    w_ctr_nxt;
   logic [LIMW-1:0] r_rem;
   logic [M-1:0]    r_inc;
   logic [CW-1:0]   w_field;
   logic            w_hs;

   assign w_hs      = (r_state == S_RUN) & out_ready;
   assign out_block = r_ctr;

`ifdef CTR_WRAP_DET_EN
   logic [CW:0] w_sum;
   logic        r_wrap;

   assign w_sum     = {1'b0, r_ctr[CW-1:0]} + (CW+1)'(r_inc);
   assign w_field   = w_sum[CW-1:0];
   assign wrap_flag = r_wrap;

   // Sticky until the next accepted load; a carry never blocks emission.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrap <= 1'b0;
      end else if ((r_state == S_IDLE) && load) begin
         r_wrap <= 1'b0;
      end else if (w_hs && w_sum[CW]) begin
         r_wrap <= 1'b1;
      end
   end
`else
   assign w_field   = r_ctr[CW-1:0] + CW'(r_inc);
   assign wrap_flag = 1'b0;
`endif

   // The nonce portion never receives a carry out of the counter field.
   generate
      if (CW < N) begin : g_nonce
         assign w_ctr_nxt = {r_ctr[N-1:CW], w_field};
      end else begin : g_full
         assign w_ctr_nxt = w_field;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctr <= '0;
         r_rem <= '0;
         r_inc <= '0;
      end else if (r_state == S_IDLE) begin
         if (load) begin
            r_ctr <= load_val;
         end
         if (start) begin
            r_rem <= num_blocks;
            r_inc <= inc;
         end
      end else if (w_hs) begin
         r_ctr <= w_ctr_nxt;
         r_rem <= r_rem - LIMW'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      out_valid   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (num_blocks != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (w_hs && (r_rem == LIMW'(1))) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
